// File: rtl/regfile_psr.sv
// regfile_psr
// Operand-supply and status-storage stage sitting directly in front of the ALU.
// Holds a 2^REG_BITS x WIDTH general register file and the processor status
// register (PSR) that captures ALU flags.
//
// Ports:
//   i_clk          sole clock, all state updates on the rising edge
//   i_reset        synchronous active-high reset, clears registers and PSR
//   i_reg_write    write enable for the write-back port
//   i_wr_addr      destination register
//   i_wr_data      write-back data
//   i_rd_addr_a    operand A source register
//   i_rd_addr_b    operand B source register
//   o_rd_a         operand A (write-through bypassed)
//   o_rd_b         operand B (write-through bypassed)
//   i_dbg_addr     debug read address
//   o_dbg_data     debug read data (committed state only, no bypass)
//   i_psr_in       flag vector from the ALU
//   i_psr_we_arith latch C (bit 0) and F (bit 5)
//   i_psr_we_cmp   latch L (bit 2), Z (bit 6) and N (bit 7)
//   o_psr_out      stored PSR
module regfile_psr #(
  parameter int WIDTH    = 16,
  parameter int REG_BITS = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_reg_write,
  input  logic [REG_BITS-1:0] i_wr_addr,
  input  logic [WIDTH-1:0]    i_wr_data,
  input  logic [REG_BITS-1:0] i_rd_addr_a,
  input  logic [REG_BITS-1:0] i_rd_addr_b,
  output logic [WIDTH-1:0]    o_rd_a,
  output logic [WIDTH-1:0]    o_rd_b,
  input  logic [REG_BITS-1:0] i_dbg_addr,
  output logic [WIDTH-1:0]    o_dbg_data,
  input  logic [WIDTH-1:0]    i_psr_in,
  input  logic                i_psr_we_arith,
  input  logic                i_psr_we_cmp,
  output logic [WIDTH-1:0]    o_psr_out
);

  localparam int NumRegs = 1 << REG_BITS;

  // Flag groups: arithmetic owns C and F, compare owns L, Z and N.
  // Every other PSR bit is reserved and must never become 1.
  localparam logic [WIDTH-1:0] ArithMask = WIDTH'(16'h0021);
  localparam logic [WIDTH-1:0] CmpMask   = WIDTH'(16'h00C4);

  logic [WIDTH-1:0] r_regs [NumRegs];
  logic [WIDTH-1:0] r_psr;
  logic [WIDTH-1:0] w_psrMask;

  // Register array: reset clears every entry and wins over a pending write,
  // otherwise the write-back port commits one word per cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_reg_write) begin
      r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  // Build the set of PSR bits that load this cycle from the two group
  // enables; both high simply merges the groups.
  always_comb begin
    w_psrMask = '0;
    if (i_psr_we_arith) w_psrMask = w_psrMask | ArithMask;
    if (i_psr_we_cmp)   w_psrMask = w_psrMask | CmpMask;
  end

  // PSR storage: only masked bits load, so reserved bits stay at their
  // reset value of zero regardless of what the ALU drives on them.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_psr <= '0;
    end else begin
      r_psr <= (r_psr & ~w_psrMask) | (i_psr_in & w_psrMask);
    end
  end

  // Operand reads bypass the write-back data so an instruction can consume
  // a result written in the same cycle. The bypass is purely combinational
  // and therefore still active while reset is asserted.
  always_comb begin
    o_rd_a = r_regs[i_rd_addr_a];
    o_rd_b = r_regs[i_rd_addr_b];
    if (i_reg_write && (i_rd_addr_a == i_wr_addr)) o_rd_a = i_wr_data;
    if (i_reg_write && (i_rd_addr_b == i_wr_addr)) o_rd_b = i_wr_data;
  end

  // Debug port shows committed state only.
  assign o_dbg_data = r_regs[i_dbg_addr];
  assign o_psr_out  = r_psr;

endmodule

// File: doc/regfile_psr.md
# regfile_psr

- Operand-supply and status-storage stage directly upstream of the ALU.
- 16-entry × 16-bit general register file:
  - two combinational read ports (operands A and B);
  - one synchronous write port (write-back);
  - a third read port for debug and verification.
- Holds the processor status register (PSR):
  - latches the ALU's `psr_flags` under per-group write enables;
  - drives the stored flags back to the branch/condition logic.

## Interface
Parameters:
- `WIDTH`, 16, data and register width
- `REG_BITS`, 4, register address width (2^REG_BITS registers)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all registers and PSR
- `reg_write`  in  1  write enable for the write port
- `wr_addr`  in  REG_BITS  destination register
- `wr_data`  in  WIDTH  write-back data (ALU result or load data)
- `rd_addr_a`  in  REG_BITS  operand A source register
- `rd_addr_b`  in  REG_BITS  operand B source register
- `rd_a`  out  WIDTH  operand A, feeds ALU `a`
- `rd_b`  out  WIDTH  operand B, feeds ALU `b` (immediate muxing is external)
- `dbg_addr`  in  REG_BITS  debug read address
- `dbg_data`  out  WIDTH  debug read data
- `psr_in`  in  WIDTH  flag vector from ALU
- `psr_we_arith`  in  1  latch C (bit 0) and F (bit 5)
- `psr_we_cmp`  in  1  latch L (bit 2), Z (bit 6) and N (bit 7)
- `psr_out`  out  WIDTH  stored PSR

## Operation
- **Register storage:** 2^REG_BITS words of WIDTH bits. All registers, including r0, are general purpose and writable.
- **Write:**
  - On a rising edge with `reg_write`=1 and `reset`=0, `regs[wr_addr] <= wr_data`.
  - With `reg_write`=0, the register array holds.
- **Read ports A and B:** combinational, with write-through bypass.
  - If `reg_write`=1 and `rd_addr_x == wr_addr`, then `rd_x = wr_data`.
  - Otherwise `rd_x = regs[rd_addr_x]`.
  - Both ports may address the same register; both then return the same value, bypassed if applicable.
- **Debug port:** `dbg_data = regs[dbg_addr]`. No bypass; it shows committed state only.
- **PSR layout:** {8'b0, N, Z, F, 2'b0, L, 1'b0, C}.
  - Bits 15:8, 4, 3 and 1 are reserved.
  - Reserved bits are always stored and driven as 0, whatever `psr_in` carries.
- **PSR update** (rising edge, `reset`=0):
  - `psr_we_arith`=1: bit 0 <= `psr_in[0]`, bit 5 <= `psr_in[5]`.
  - `psr_we_cmp`=1: bit 2 <= `psr_in[2]`, bit 6 <= `psr_in[6]`, bit 7 <= `psr_in[7]`.
  - Both enables high: all five flag bits update in the same edge.
  - Neither enable high: PSR holds.
- **PSR read:** `psr_out` is the registered value. There is no bypass, so a flag written in cycle n is visible from cycle n+1.

## Timing
- **Reset:** on a rising edge with `reset`=1:
  - every register, and therefore `dbg_data`, becomes 0x0000;
  - `psr_out` becomes 0x0000.
- **Reset priority:** reset overrides `reg_write` and both PSR enables in the same cycle.
- **Reset mid-operation:**
  - a write presented in the reset cycle is discarded;
  - while `reset` is high, `rd_a`/`rd_b` still bypass `wr_data` combinationally when `reg_write`=1.
- **Register write latency:**
  - 0 cycles to `rd_a`/`rd_b` via the bypass;
  - 1 cycle to `dbg_data` and to non-bypassed reads.
- **PSR latency:** 1 cycle from enable to `psr_out`.
- **No stall or handshake:** a write is accepted every cycle; back-to-back writes to the same address keep the last one.
- **Address range:** full range only (REG_BITS bits), so no out-of-range case exists.

## Test plan
- **Reset:**
  - Stimulus: preload r3=0xBEEF and PSR=0x00E5; assert `reset` for 1 cycle with `reg_write`=1, `wr_addr`=3, `wr_data`=0x1234.
  - Response: `dbg_data`(r3)=0x0000 and `psr_out`=0x0000 after the edge.
- **Write/read:**
  - Stimulus: write r0..r15 with 0x1000+i in consecutive cycles, then sweep `rd_addr_a`/`rd_addr_b`.
  - Response: each port returns 0x1000+i; r0 holds 0x1000.
- **Bypass:**
  - Stimulus: r5=0x00AA; in one cycle set `reg_write`=1, `wr_addr`=5, `wr_data`=0x5555, `rd_addr_a`=`rd_addr_b`=5.
  - Response: `rd_a`=`rd_b`=0x5555 in that cycle; `dbg_data`(r5)=0x00AA that cycle and 0x5555 the next.
- **PSR group masking:**
  - Stimulus: with PSR=0, apply `psr_in`=0xFFFF and `psr_we_arith`=1.
  - Response: `psr_out`=0x0021.
  - Stimulus: then apply `psr_in`=0xFFFF and `psr_we_cmp`=1.
  - Response: `psr_out`=0x00E5.
- **PSR hold and simultaneous enables:**
  - Stimulus: with PSR=0x00E5, apply `psr_in`=0x0000 with both enables low for 3 cycles.
  - Response: `psr_out` stays 0x00E5.
  - Stimulus: then assert both enables with `psr_in`=0x0044.
  - Response: `psr_out`=0x0044 after 1 edge.
